// File: rtl/adder_arb_pkg.sv
// Shared defaults and response record for the adder arbiter slice.
package adder_arb_pkg;

    localparam int WIDTH = 6;
    localparam int N_REQ = 4;
    localparam int CNT_W = 16;
    localparam int ID_W  = $clog2(N_REQ);

    // One registered result: owning requester, wrapped sum and carry-out.
    typedef struct packed {
        logic [ID_W-1:0]  id;
        logic [WIDTH-1:0] sum;
        logic             cout;
    } rsp_t;

endpackage

// File: rtl/adder.sv
// Combinational WIDTH-bit adder with carry-out; the shared datapath.
module adder #(
    parameter int WIDTH = 6
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] s,
    output logic             cout
);

    // Widen by one bit so the carry falls out as the top bit of the sum.
    assign {cout, s} = {1'b0, x} + {1'b0, y};

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin selector: first set request at or after ptr, wrapping to 0.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] idx,
    output logic                 any
);

    localparam int IW = $clog2(N);

    function automatic int wrap_idx(input int a);
        return (a >= N) ? (a - N) : a;
    endfunction

    // Scan N positions starting at ptr; the first hit wins and stops the search.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!any && req[wrap_idx(int'(ptr) + k)]) begin
                any                            = 1'b1;
                grant[wrap_idx(int'(ptr) + k)] = 1'b1;
                idx                            = IW'(wrap_idx(int'(ptr) + k));
            end
        end
    end

endmodule

// File: rtl/adder_arbiter.sv
// Shares one adder among N_REQ requesters; registers one result with backpressure.
module adder_arbiter #(
    parameter int WIDTH = adder_arb_pkg::WIDTH,
    parameter int N_REQ = adder_arb_pkg::N_REQ,
    parameter int CNT_W = adder_arb_pkg::CNT_W,
    localparam int ID_W = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_x,
    input  logic [N_REQ*WIDTH-1:0] req_y,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic [WIDTH-1:0]       rsp_sum,
    output logic                   rsp_cout,
    output logic [CNT_W-1:0]       op_count
);

    logic [WIDTH-1:0] x_arr [N_REQ];
    logic [WIDTH-1:0] y_arr [N_REQ];

    logic [N_REQ-1:0] grant;
    logic [ID_W-1:0]  win_idx;
    logic             win_any;
    logic             can_load;
    logic             load;
    logic             drain;

    logic [WIDTH-1:0] op_x;
    logic [WIDTH-1:0] op_y;
    logic [WIDTH-1:0] add_s;
    logic             add_cout;

    logic             rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]  rsp_id_q,    rsp_id_d;
    logic [WIDTH-1:0] rsp_sum_q,   rsp_sum_d;
    logic             rsp_cout_q,  rsp_cout_d;
    logic [ID_W-1:0]  ptr_q,       ptr_d;
    logic [CNT_W-1:0] op_count_q,  op_count_d;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_slice
            assign x_arr[gi] = req_x[gi*WIDTH +: WIDTH];
            assign y_arr[gi] = req_y[gi*WIDTH +: WIDTH];
        end
    endgenerate

    rr_arbiter #(
        .N (N_REQ)
    ) u_rr (
        .req   (req_valid),
        .ptr   (ptr_q),
        .grant (grant),
        .idx   (win_idx),
        .any   (win_any)
    );

    // A full register only takes a new result when it is being drained this
    // cycle; reset also forces ready low so nothing is accepted while held.
    assign can_load  = !rsp_valid_q || rsp_ready;
    assign req_ready = (rst_n && can_load) ? grant : '0;
    assign load      = rst_n && can_load && win_any;
    assign drain     = rsp_valid_q && rsp_ready;

    // AND-OR operand mux keyed by the one-hot grant; no index decode needed.
    always_comb begin
        op_x = '0;
        op_y = '0;
        for (int i = 0; i < N_REQ; i++) begin
            op_x = op_x | ({WIDTH{grant[i]}} & x_arr[i]);
            op_y = op_y | ({WIDTH{grant[i]}} & y_arr[i]);
        end
    end

    adder #(
        .WIDTH (WIDTH)
    ) u_adder (
        .x    (op_x),
        .y    (op_y),
        .s    (add_s),
        .cout (add_cout)
    );

    // Next state: load overwrites (even while draining), drain alone empties.
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_cout_d  = rsp_cout_q;
        ptr_d       = ptr_q;
        op_count_d  = op_count_q;
        if (drain) begin
            rsp_valid_d = 1'b0;
            if (op_count_q != {CNT_W{1'b1}}) begin
                op_count_d = op_count_q + CNT_W'(1);
            end
        end
        if (load) begin
            rsp_valid_d = 1'b1;
            rsp_id_d    = win_idx;
            rsp_sum_d   = add_s;
            rsp_cout_d  = add_cout;
            ptr_d       = (win_idx == ID_W'(N_REQ - 1)) ? '0 : win_idx + ID_W'(1);
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_sum_q   <= '0;
            rsp_cout_q  <= 1'b0;
            ptr_q       <= '0;
            op_count_q  <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_cout_q  <= rsp_cout_d;
            ptr_q       <= ptr_d;
            op_count_q  <= op_count_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_cout  = rsp_cout_q;
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Scoreboard bench for adder_arbiter: a reference arbiter predicts grants,
// expected results queue at the grant and are compared while held / drained.
module tb_adder_arbiter;
    import adder_arb_pkg::*;

    localparam int CW  = 4;
    localparam int MAXC = (1 << CW) - 1;

    logic                   clk;
    logic                   rst_n;
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ*WIDTH-1:0] req_x;
    logic [N_REQ*WIDTH-1:0] req_y;
    logic [N_REQ-1:0]       req_ready;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [ID_W-1:0]        rsp_id;
    logic [WIDTH-1:0]       rsp_sum;
    logic                   rsp_cout;
    logic [CW-1:0]          op_count;

    adder_arbiter #(
        .WIDTH (WIDTH),
        .N_REQ (N_REQ),
        .CNT_W (CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_x     (req_x),
        .req_y     (req_y),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .op_count  (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Requester-side state
    logic [WIDTH-1:0] x_b [N_REQ];
    logic [WIDTH-1:0] y_b [N_REQ];
    logic [N_REQ-1:0] auto_mask;
    logic [N_REQ-1:0] acc_mask;

    // Reference model state
    rsp_t sb[$];
    int   glog[$];
    int   ptr_m;
    int   cnt_m;

    task automatic pack();
        for (int i = 0; i < N_REQ; i++) begin
            req_x[i*WIDTH +: WIDTH] = x_b[i];
            req_y[i*WIDTH +: WIDTH] = y_b[i];
        end
    endtask

    task automatic post(input int i, input int x, input int y);
        x_b[i] = WIDTH'(x);
        y_b[i] = WIDTH'(y);
        req_valid[i] = 1'b1;
        pack();
    endtask

    // Advance one clock; accepted requesters drop or refill with new operands.
    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < N_REQ; i++) begin
            if (acc_mask[i]) begin
                if (auto_mask[i]) post(i, int'($urandom_range(0, 63)), int'($urandom_range(0, 63)));
                else req_valid[i] = 1'b0;
            end
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (req_valid != '0 && n < 50) begin
            step();
            n++;
        end
        check("idle_timeout", {31'd0, req_valid == '0}, 32'd1);
    endtask

    // Per-cycle monitor: checks handshake, held response and counter.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            ptr_m    = 0;
            cnt_m    = 0;
            acc_mask = '0;
        end else begin
            logic [N_REQ-1:0] exp_rdy;
            int w;
            int s;
            rsp_t e;
            bit can_m;
            can_m   = (sb.size() == 0) || rsp_ready;
            w       = -1;
            for (int k = 0; k < N_REQ; k++) begin
                if (w < 0 && req_valid[(ptr_m + k) % N_REQ]) w = (ptr_m + k) % N_REQ;
            end
            exp_rdy = '0;
            if (w >= 0 && can_m) exp_rdy[w] = 1'b1;
            check("req_ready", 32'(req_ready), 32'(exp_rdy));
            check("rsp_valid", {31'd0, rsp_valid}, {31'd0, sb.size() != 0});
            check("op_count", 32'(op_count), 32'(cnt_m));
            if (sb.size() != 0) begin
                check("rsp_id", 32'(rsp_id), 32'(sb[0].id));
                check("rsp_sum", 32'(rsp_sum), 32'(sb[0].sum));
                check("rsp_cout", {31'd0, rsp_cout}, {31'd0, sb[0].cout});
                if (rsp_ready) begin
                    $display("rsp id=%0d sum=%0d cout=%0d count=%0d", rsp_id, rsp_sum, rsp_cout, op_count);
                    void'(sb.pop_front());
                    if (cnt_m < MAXC) cnt_m++;
                end
            end
            if (exp_rdy != '0) begin
                s      = int'(req_x[w*WIDTH +: WIDTH]) + int'(req_y[w*WIDTH +: WIDTH]);
                e.id   = ID_W'(w);
                e.sum  = s[WIDTH-1:0];
                e.cout = s[WIDTH];
                sb.push_back(e);
                glog.push_back(w);
                ptr_m  = (w + 1) % N_REQ;
            end
            acc_mask = req_valid & req_ready;
        end
    end

    initial begin
        rst_n     = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b1;
        auto_mask = '0;
        for (int i = 0; i < N_REQ; i++) begin
            x_b[i] = '0;
            y_b[i] = '0;
        end
        pack();
        #1 rst_n = 1'b0;
        #1;
        check("rst_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_id", 32'(rsp_id), 32'd0);
        check("rst_sum", 32'(rsp_sum), 32'd0);
        check("rst_cout", {31'd0, rsp_cout}, 32'd0);
        check("rst_count", 32'(op_count), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single requester, then wrap-around operand cases
        post(0, 5, 9);
        wait_idle();
        step();
        check("single_count", 32'(op_count), 32'd1);
        post(1, 63, 1);
        wait_idle();
        post(2, 40, 30);
        wait_idle();
        post(3, 0, 0);
        wait_idle();
        step();

        // All four continuously valid: strict rotation, no bubbles
        glog.delete();
        auto_mask = '1;
        for (int i = 0; i < N_REQ; i++) post(i, int'($urandom_range(0, 63)), int'($urandom_range(0, 63)));
        repeat (6) step();
        auto_mask = '0;
        wait_idle();
        for (int i = 0; i < 6; i++) check("rr_order", 32'(glog[i]), 32'(i % 4));

        // Move ptr to 2, then only requesters 0 and 3 contend
        post(1, 1, 1);
        wait_idle();
        step();
        glog.delete();
        auto_mask = 4'b1001;
        post(0, 11, 12);
        post(3, 13, 14);
        repeat (3) step();
        auto_mask = '0;
        wait_idle();
        check("ptr2_g0", 32'(glog[0]), 32'd3);
        check("ptr2_g1", 32'(glog[1]), 32'd0);
        check("ptr2_g2", 32'(glog[2]), 32'd3);
        step();

        // Backpressure: held result, blocked requester, same-cycle reload
        rsp_ready = 1'b0;
        post(0, 10, 20);
        step();
        post(1, 7, 8);
        repeat (3) step();
        check("bp_sum", 32'(rsp_sum), 32'd30);
        check("bp_id", 32'(rsp_id), 32'd0);
        check("bp_ready", 32'(req_ready), 32'd0);
        rsp_ready = 1'b1;
        step();
        check("bp_stay_valid", {31'd0, rsp_valid}, 32'd1);
        check("bp_new_id", 32'(rsp_id), 32'd1);
        check("bp_new_sum", 32'(rsp_sum), 32'd15);
        wait_idle();
        step();

        // Reset mid-operation with requester 2 pending
        rsp_ready = 1'b0;
        post(0, 1, 2);
        step();
        post(2, 3, 4);
        step();
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
        check("mid_rst_sum", 32'(rsp_sum), 32'd0);
        check("mid_rst_id", 32'(rsp_id), 32'd0);
        check("mid_rst_cout", {31'd0, rsp_cout}, 32'd0);
        check("mid_rst_count", 32'(op_count), 32'd0);
        check("mid_rst_ready", 32'(req_ready), 32'd0);
        rsp_ready = 1'b1;
        step();
        rst_n = 1'b1;
        step();
        check("post_rst_valid", {31'd0, rsp_valid}, 32'd1);
        check("post_rst_id", 32'(rsp_id), 32'd2);
        check("post_rst_sum", 32'(rsp_sum), 32'd7);
        wait_idle();

        // Saturation: 20+ operations on a 4-bit counter
        auto_mask = '1;
        for (int i = 0; i < N_REQ; i++) post(i, int'($urandom_range(0, 63)), int'($urandom_range(0, 63)));
        repeat (20) step();
        auto_mask = '0;
        wait_idle();
        repeat (2) step();
        check("sat_count", 32'(op_count), 32'(MAXC));
        check("drained", 32'(sb.size()), 32'd0);
        check("final_valid", {31'd0, rsp_valid}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/adder_arbiter.md
# adder_arbiter

Round-robin arbiter and sequencer that shares one combinational 6-bit `adder` instance among N_REQ requesters. Each requester presents an X/Y operand pair under a valid/ready handshake. The block grants one requester per cycle and registers the sum, carry-out and requester ID into a single-entry response register with backpressure. It sits between the client blocks and the adder datapath and is the only instantiator of `adder`.

## Interface
Parameters:
- WIDTH, 6, operand/sum width; must match `adder` port width
- N_REQ, 4, number of requesters (2..8)
- CNT_W, 16, width of the completed-operation counter

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; one clock, asynchronous, active-low
- req_valid  in  N_REQ  bit i: requester i presents operands
- req_x  in  N_REQ*WIDTH  operand X; slice i at [i*WIDTH +: WIDTH]
- req_y  in  N_REQ*WIDTH  operand Y; same slicing as req_x
- req_ready  out  N_REQ  one-hot or zero; bit i: requester i accepted this cycle
- rsp_valid  out  1  response register holds a result
- rsp_ready  in  1  consumer accepts the response
- rsp_id  out  $clog2(N_REQ)  index of the requester that owns the result
- rsp_sum  out  WIDTH  (X+Y) mod 2^WIDTH
- rsp_cout  out  1  carry-out of X+Y
- op_count  out  CNT_W  completed responses; saturating

## Operation
- `can_load = !rsp_valid || rsp_ready`.
- Arbitration uses priority pointer `ptr`. The winner is the first set req_valid bit searching ptr, ptr+1, …, wrapping to 0.
- `req_ready[winner] = can_load`. All other bits are 0. When no request is valid, req_ready = 0.
- On a handshake (req_valid[i] && req_ready[i]):
  - The winner's operands drive `adder` combinationally.
  - S and cout are captured into rsp_sum/rsp_cout. rsp_id takes i and rsp_valid takes 1.
  - `ptr` takes (i+1) mod N_REQ.
- A handshake with no pending load leaves `ptr` unchanged.
- On a response handshake (rsp_valid && rsp_ready):
  - op_count increments and saturates at 2^CNT_W−1.
  - If no new grant happens in the same cycle, rsp_valid goes to 0.
- Simultaneous response drain and new grant in one cycle: the new result overwrites the register and rsp_valid stays 1. No bubble is inserted.
- Requesters hold req_valid and operands stable until accepted. The arbiter never accepts data without asserting req_ready.
- While rsp_valid && !rsp_ready:
  - rsp_* are held stable.
  - req_ready = 0.
  - ptr is frozen.
- Arithmetic wraps modulo 2^WIDTH. cout is bit WIDTH of the full sum.

## Timing
- Reset values: rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_cout=0, op_count=0, ptr=0. req_ready is combinational and therefore 0 during reset.
- Latency: a request accepted at edge N is visible on rsp_* after edge N. That is one cycle of latency.
- Throughput is one result per cycle when rsp_ready is held at 1.
- req_ready depends combinationally on req_valid and rsp_ready. There is no combinational path from req_x/req_y to any output.
- Reset asserted mid-operation clears everything immediately. The in-flight result is discarded. A still-valid request is re-arbitrated from ptr=0 after release.

## Structure
- Package `adder_arb_pkg` holds: WIDTH, N_REQ and CNT_W defaults, ID_W = $clog2(N_REQ), and the `rsp_t` struct {id, sum, cout}.
- Sub-module `rr_arbiter` (N parameter) performs round-robin select: inputs req, ptr; outputs one-hot grant and encoded index.
- Top-level contents: operand mux, `adder` instance, response register, ptr register, op_count.

## Test plan
- Requester 0 only, X=5, Y=9, rsp_ready=1 → req_ready[0] high for 1 cycle. Next cycle: rsp_sum=14, rsp_cout=0, rsp_id=0, op_count=1.
- Wrap-around: X=63, Y=1 → sum=0, cout=1. X=40, Y=30 → sum=6, cout=1. X=0, Y=0 → sum=0, cout=0.
- All 4 requesters continuously valid, rsp_ready=1 → grant order 0,1,2,3,0,1, one response per cycle, no bubbles. Also start with ptr=2 and only requesters 0 and 3 valid → grants 3,0,3.
- Backpressure: rsp_ready=0 for 3 cycles with a result held → rsp_* stable, req_ready=0, ptr unchanged. When rsp_ready returns to 1, the next winner loads in the same cycle and rsp_valid stays 1.
- Reset mid-operation: assert rst_n=0 while rsp_valid=1 and requester 2 is pending → all outputs 0 immediately. After release, requester 2 is granted with ptr search starting at 0.
- Counter saturation: preload op_count near 2^16−1 (or CNT_W=4) and run 20 ops → op_count stops at max and never wraps.
